// File: rtl/packet_switch_pkg.sv
// Shared lookup->egress types: segment sideband, egress port enum and the
// width-adjust buffer entry, plus the bytesvld->tkeep helper.
package packet_switch_pkg;

  localparam int PKT_TDATA_WIDTH        = 512;
  localparam int PKT_TKEEP_WIDTH        = PKT_TDATA_WIDTH / 8;
  localparam int PKT_USERMETADATA_WIDTH = 1;
  localparam int PKT_OUT_DATA_WIDTH     = 64;
  localparam int PKT_OUT_KEEP_WIDTH     = PKT_OUT_DATA_WIDTH / 8;
  localparam int PKT_RATIO              = PKT_TDATA_WIDTH / PKT_OUT_DATA_WIDTH;
  localparam int BYTESVLD_WIDTH         = $clog2(PKT_TKEEP_WIDTH);
  localparam int NSUB_WIDTH             = $clog2(PKT_RATIO) + 1;
  localparam int REM_WIDTH              = $clog2(PKT_OUT_KEEP_WIDTH);

  typedef enum logic [1:0] {
    PORT_0,
    PORT_1,
    PORT_2,
    PORT_3
  } PORT_E;

  // bytesvld == 0 on an eop segment means the whole beat is valid
  typedef struct packed {
    logic                      sop;
    logic                      eop;
    logic [BYTESVLD_WIDTH-1:0] bytesvld;
    PORT_E                     egr_port;
  } SEGMENT_INFO_S;

  typedef struct packed {
    logic [PKT_TDATA_WIDTH-1:0]        data;
    logic [NSUB_WIDTH-1:0]             nsub;
    logic [REM_WIDTH-1:0]              rem;
    logic                              sop;
    logic                              eop;
    logic [PKT_USERMETADATA_WIDTH-1:0] usermetadata;
    PORT_E                             egr_port;
  } EWADJ_ENTRY_S;

  function automatic logic [PKT_TKEEP_WIDTH-1:0] cal_bytesvld2tkeep(
    input logic                      eop,
    input logic [BYTESVLD_WIDTH-1:0] bytesvld
  );
    logic [PKT_TKEEP_WIDTH-1:0] ones;
    ones = '1;
    if (!eop || bytesvld == '0) return ones;
    return ones >> (PKT_TKEEP_WIDTH - int'(bytesvld));
  endfunction

endpackage

// File: rtl/packet_switch_egr_wadj_fifo.sv
// Synchronous show-ahead FIFO of width-adjust entries; the head entry is
// visible on rdata whenever empty is low.
module packet_switch_egr_wadj_fifo
  import packet_switch_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  EWADJ_ENTRY_S               wdata,
  input  logic                       pop,
  output EWADJ_ENTRY_S               rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int AW = $clog2(DEPTH);

  EWADJ_ENTRY_S mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are live, so a flush costs nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign occ   = wr_ptr - rd_ptr;
  assign empty = (occ == '0);
  assign full  = occ[AW];
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/packet_switch_egr_wadj.sv
// Egress width adjust: buffers full-width lookup segments and narrows each
// beat into OUT_DATA_WIDTH AXI-S sub-beats with a registered output stage.
module packet_switch_egr_wadj
  import packet_switch_pkg::*;
#(
  parameter int TDATA_WIDTH        = PKT_TDATA_WIDTH,
  parameter int TKEEP_WIDTH        = TDATA_WIDTH / 8,
  parameter int USERMETADATA_WIDTH = PKT_USERMETADATA_WIDTH,
  parameter int OUT_DATA_WIDTH     = PKT_OUT_DATA_WIDTH,
  parameter int OUT_KEEP_WIDTH     = OUT_DATA_WIDTH / 8,
  parameter int FIFO_DEPTH         = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          lu2ewadj_tvalid,
  input  logic [TDATA_WIDTH-1:0]        lu2ewadj_tdata,
  input  logic [TKEEP_WIDTH-1:0]        lu2ewadj_tkeep,
  input  logic [USERMETADATA_WIDTH-1:0] lu2ewadj_tuser_usermetadata,
  input  SEGMENT_INFO_S                 lu2ewadj_tuser_segment_info,
  output logic                          ewadj2lu_tready,
  output logic                          ewadj2egr_tvalid,
  input  logic                          egr2ewadj_tready,
  output logic [OUT_DATA_WIDTH-1:0]     ewadj2egr_tdata,
  output logic [OUT_KEEP_WIDTH-1:0]     ewadj2egr_tkeep,
  output logic                          ewadj2egr_tlast,
  output logic [USERMETADATA_WIDTH-1:0] ewadj2egr_tuser_usermetadata,
  output PORT_E                         ewadj2egr_tuser_egr_port,
  output logic                          err_no_sop,
  output logic                          err_sop_in_pkt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_occ
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUB_W = NSUB_WIDTH - 1;
  localparam int NB_W  = BYTESVLD_WIDTH + 1;
  localparam logic [OCC_W:0] READY_LIMIT = (OCC_W + 1)'(FIFO_DEPTH - 2);

  typedef enum logic {WAIT_SOP, IN_PKT} wr_state_e;

  SEGMENT_INFO_S    info;
  wr_state_e        state;
  wr_state_e        state_nxt;
  logic             accept;
  logic             push;
  logic             pop;
  logic             no_sop_nxt;
  logic             sop_in_pkt_nxt;
  logic [NB_W-1:0]  nbytes;
  EWADJ_ENTRY_S     wr_entry;
  EWADJ_ENTRY_S     head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [OCC_W:0]   occ_nxt;
  logic [SUB_W-1:0] k;
  logic             out_free;
  logic             load;
  logic             last_sub;
  logic [OUT_KEEP_WIDTH-1:0] sub_keep;
  logic [OUT_KEEP_WIDTH-1:0] ones_keep;

  assign info   = lu2ewadj_tuser_segment_info;
  assign accept = lu2ewadj_tvalid & ewadj2lu_tready;

  // ---------------- write side ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SOP;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before any branch so no
  // path leaves a signal unassigned (which would infer a latch); blocking '='
  // is correct here because this is combinational logic, not state.
  always_comb begin
    state_nxt      = state;
    push           = 1'b0;
    no_sop_nxt     = 1'b0;
    sop_in_pkt_nxt = 1'b0;
    if (accept) begin
      case (state)
        WAIT_SOP: begin
          if (info.sop) begin
            push      = 1'b1;
            state_nxt = info.eop ? WAIT_SOP : IN_PKT;
          end else begin
            no_sop_nxt = 1'b1;
          end
        end
        IN_PKT: begin
          // A stray sop restarts the packet; the unterminated one is not fixed up
          push           = 1'b1;
          sop_in_pkt_nxt = info.sop;
          state_nxt      = info.eop ? WAIT_SOP : IN_PKT;
        end
        default: state_nxt = WAIT_SOP;
      endcase
    end
  end

  always_comb begin
    nbytes = NB_W'(TKEEP_WIDTH);
    if (info.eop && info.bytesvld != '0) nbytes = {1'b0, info.bytesvld};
    wr_entry.data         = lu2ewadj_tdata;
    wr_entry.nsub         = NSUB_WIDTH'((nbytes + NB_W'(OUT_KEEP_WIDTH - 1)) >> REM_WIDTH);
    wr_entry.rem          = REM_WIDTH'(nbytes);
    wr_entry.sop          = info.sop;
    wr_entry.eop          = info.eop;
    wr_entry.usermetadata = lu2ewadj_tuser_usermetadata;
    wr_entry.egr_port     = info.egr_port;
  end

  packet_switch_egr_wadj_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .occ   (fifo_occ)
  );

  // Ready looks at occupancy after this cycle's push/pop, leaving one slot
  // to absorb the beat that may land while ready is still high.
  assign occ_nxt = {1'b0, fifo_occ} + (OCC_W + 1)'(push) - (OCC_W + 1)'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ewadj2lu_tready <= 1'b0;
      err_no_sop      <= 1'b0;
      err_sop_in_pkt  <= 1'b0;
    end else begin
      ewadj2lu_tready <= (occ_nxt <= READY_LIMIT);
      err_no_sop      <= no_sop_nxt;
      err_sop_in_pkt  <= sop_in_pkt_nxt;
    end
  end

  // ---------------- read side ----------------
  assign out_free = ~ewadj2egr_tvalid | egr2ewadj_tready;
  assign load     = out_free & ~fifo_empty;
  assign last_sub = ({1'b0, k} == head.nsub - 1'b1);
  assign pop      = load & last_sub;

  always_comb begin
    ones_keep = '1;
    sub_keep  = ones_keep;
    if (last_sub && head.eop && head.rem != '0)
      sub_keep = ones_keep >> (OUT_KEEP_WIDTH - int'(head.rem));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k                            <= '0;
      ewadj2egr_tvalid             <= 1'b0;
      ewadj2egr_tdata              <= '0;
      ewadj2egr_tkeep              <= '0;
      ewadj2egr_tlast              <= 1'b0;
      ewadj2egr_tuser_usermetadata <= '0;
      ewadj2egr_tuser_egr_port     <= PORT_0;
    end else if (load) begin
      ewadj2egr_tvalid <= 1'b1;
      ewadj2egr_tdata  <= head.data[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
      ewadj2egr_tkeep  <= sub_keep;
      ewadj2egr_tlast  <= head.eop & last_sub;
      if (head.sop && k == '0) begin
        ewadj2egr_tuser_usermetadata <= head.usermetadata;
        ewadj2egr_tuser_egr_port     <= head.egr_port;
      end
      k <= last_sub ? '0 : k + 1'b1;
    end else if (out_free) begin
      ewadj2egr_tvalid <= 1'b0;
    end
  end

  a_no_write_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full));

  a_tkeep_matches_bytesvld : assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (lu2ewadj_tkeep == cal_bytesvld2tkeep(info.eop, info.bytesvld)));

endmodule

// File: tb/tb_packet_switch_egr_wadj.sv
// Scoreboard bench for packet_switch_egr_wadj: a driver pushes expected
// egress sub-beats, an independent monitor pops and compares on handshake.
module tb_packet_switch_egr_wadj;
  import packet_switch_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        meta;
    PORT_E       port;
  } sub_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lu_tvalid = 1'b0;
  logic [511:0]  lu_tdata = '0;
  logic [63:0]   lu_tkeep = '0;
  logic [0:0]    lu_meta = '0;
  SEGMENT_INFO_S seg_info = '0;
  logic          lu_tready;
  logic          egr_tvalid;
  logic          egr_tready = 1'b0;
  logic [63:0]   egr_tdata;
  logic [7:0]    egr_tkeep;
  logic          egr_tlast;
  logic [0:0]    egr_meta;
  PORT_E         egr_port;
  logic          err_no_sop;
  logic          err_sop_in_pkt;
  logic [5:0]    fifo_occ;

  int   checks = 0;
  int   errors = 0;
  sub_t sb[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   hs_total = 0;
  int   tlast_cnt = 0;
  int   max_occ = 0;
  int   rdy_mode = 0;
  sub_t last_act;
  logic model_in_pkt = 1'b0;
  logic cur_meta = 1'b0;
  PORT_E cur_port = PORT_0;

  packet_switch_egr_wadj dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .lu2ewadj_tvalid              (lu_tvalid),
    .lu2ewadj_tdata               (lu_tdata),
    .lu2ewadj_tkeep               (lu_tkeep),
    .lu2ewadj_tuser_usermetadata  (lu_meta),
    .lu2ewadj_tuser_segment_info  (seg_info),
    .ewadj2lu_tready              (lu_tready),
    .ewadj2egr_tvalid             (egr_tvalid),
    .egr2ewadj_tready             (egr_tready),
    .ewadj2egr_tdata              (egr_tdata),
    .ewadj2egr_tkeep              (egr_tkeep),
    .ewadj2egr_tlast              (egr_tlast),
    .ewadj2egr_tuser_usermetadata (egr_meta),
    .ewadj2egr_tuser_egr_port     (egr_port),
    .err_no_sop                   (err_no_sop),
    .err_sop_in_pkt               (err_sop_in_pkt),
    .fifo_occ                     (fifo_occ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Egress ready pattern: 0 = always ready, 1 = stalled, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       egr_tready = 1'b1;
        1:       egr_tready = 1'b0;
        default: egr_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every accepted egress sub-beat against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (int'(fifo_occ) > max_occ) max_occ = int'(fifo_occ);
      if (egr_tvalid && egr_tready) begin
        sub_t act;
        act = '{data: egr_tdata, keep: egr_tkeep, last: egr_tlast, meta: egr_meta[0], port: egr_port};
        last_act = act;
        hs_cyc.push_back(cyc);
        hs_total++;
        if (egr_tlast) tlast_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL egress_unexpected: got %h expected nothing", act);
        end else begin
          check("egress_beat", 128'(act), 128'(sb.pop_front()));
        end
      end
    end
  end

  function automatic logic [63:0] seg_keep(input logic eop, input int bv);
    logic [63:0] one;
    one = 64'd1;
    if (eop && bv != 0) return (one << bv) - one;
    return '1;
  endfunction

  // Drive one segment, model the write FSM, and queue the expected sub-beats
  task automatic send_seg(input logic sop, input logic eop, input int bv,
                          input logic [511:0] data, input logic meta, input PORT_E port);
    bit   ok;
    logic exp_no_sop, exp_sop_err, stored;
    int   nbytes, nsub, rem;
    logic [7:0] ff;
    sub_t e;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (lu_tready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL lu_ready_timeout: got 0 expected 1");
      return;
    end
    lu_tvalid         = 1'b1;
    lu_tdata          = data;
    lu_tkeep          = seg_keep(eop, bv);
    lu_meta           = meta;
    seg_info.sop      = sop;
    seg_info.eop      = eop;
    seg_info.bytesvld = 6'(bv);
    seg_info.egr_port = port;
    @(posedge clk);
    #1;
    lu_tvalid = 1'b0;
    exp_no_sop  = !model_in_pkt && !sop;
    exp_sop_err = model_in_pkt && sop;
    stored      = !exp_no_sop;
    check("err_no_sop", 128'(err_no_sop), 128'(exp_no_sop));
    check("err_sop_in_pkt", 128'(err_sop_in_pkt), 128'(exp_sop_err));
    if (stored) begin
      model_in_pkt = !eop;
      if (sop) begin
        cur_meta = meta;
        cur_port = port;
      end
      nbytes = (eop && bv != 0) ? bv : 64;
      nsub   = (nbytes + 7) / 8;
      rem    = nbytes % 8;
      ff     = 8'hFF;
      for (int k = 0; k < nsub; k++) begin
        e.data = data[k*64 +: 64];
        e.keep = (eop && k == nsub - 1 && rem != 0) ? (ff >> (8 - rem)) : 8'hFF;
        e.last = eop && (k == nsub - 1);
        e.meta = cur_meta;
        e.port = cur_port;
        sb.push_back(e);
      end
    end
  endtask

  function automatic logic [511:0] build_seg(input int len, input int s, input int pid);
    logic [511:0] d;
    int idx;
    for (int b = 0; b < 64; b++) begin
      idx = s * 64 + b;
      d[b*8 +: 8] = (idx < len) ? 8'((pid * 13 + idx) & 255) : 8'hEE;
    end
    return d;
  endfunction

  task automatic send_pkt(input int len, input logic meta, input PORT_E port,
                          input int pid, input bit gaps);
    int nseg, bv;
    nseg = (len + 63) / 64;
    for (int s = 0; s < nseg; s++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      bv = (s == nseg - 1) ? (len - 64 * (nseg - 1)) % 64 : 0;
      send_seg(s == 0, s == nseg - 1, bv, build_seg(len, s, pid), meta, port);
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #3;
      if (sb.size() == 0 && !egr_tvalid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, sb.size());
    end
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    lu_tvalid = 1'b0;
    sb.delete();
    model_in_pkt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base, wr_cnt, tl0;
    bit ok;

    // Reset state
    rst_n = 1'b0;
    #12;
    check("rst_tvalid", 128'(egr_tvalid), 128'(0));
    check("rst_lu_tready", 128'(lu_tready), 128'(0));
    check("rst_occ", 128'(fifo_occ), 128'(0));
    apply_reset();
    @(posedge clk);
    #1;
    check("ready_after_reset", 128'(lu_tready), 128'(1));

    // 1) 64B single segment: 8 full sub-beats, valid two cycles after accept
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    hs_cyc.delete();
    tl0 = tlast_cnt;
    send_pkt(64, 1'b1, PORT_1, 1, 0);
    check("lat_not_yet", 128'(egr_tvalid), 128'(0));
    @(posedge clk);
    #1;
    check("lat_valid", 128'(egr_tvalid), 128'(1));
    wait_drain("t1");
    check("t1_beats", 128'(hs_cyc.size()), 128'(8));
    if (hs_cyc.size() == 8) check("t1_no_bubble", 128'(hs_cyc[7] - hs_cyc[0]), 128'(7));
    check("t1_tlast_cnt", 128'(tlast_cnt - tl0), 128'(1));

    // 2) 65B: 9 sub-beats, last is byte 64 alone
    hs_cyc.delete();
    send_pkt(65, 1'b0, PORT_2, 2, 0);
    wait_drain("t2");
    check("t2_beats", 128'(hs_cyc.size()), 128'(9));
    if (hs_cyc.size() == 9) check("t2_no_bubble", 128'(hs_cyc[8] - hs_cyc[0]), 128'(8));
    check("t2_last_keep", 128'(last_act.keep), 128'(8'h01));
    check("t2_last_data", 128'(last_act.data), 128'(64'hEEEE_EEEE_EEEE_EE5A));
    check("t2_last_tlast", 128'(last_act.last), 128'(1));

    // 3) Egress stalled: ready drops after the buffer fills to its limit
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    max_occ = 0;
    wr_cnt  = 0;
    for (int n = 0; n < 40; n++) begin
      if (!lu_tready) break;
      send_pkt(64, 1'(n), PORT_E'(n % 4), 100 + n, 0);
      wr_cnt++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("t3_writes", 128'(wr_cnt), 128'(31));
    check("t3_ready_low", 128'(lu_tready), 128'(0));
    check("t3_occ", 128'(fifo_occ), 128'(31));
    rdy_mode = 0;
    wait_drain("t3");
    check("t3_max_occ_ok", 128'(max_occ <= 32), 128'(1));
    check("t3_occ_empty", 128'(fifo_occ), 128'(0));

    // 4) Framing errors
    apply_reset();
    send_seg(1'b0, 1'b0, 0, build_seg(64, 0, 7), 1'b0, PORT_3);
    check("t4_dropped_occ", 128'(fifo_occ), 128'(0));
    send_seg(1'b1, 1'b0, 0, build_seg(128, 0, 8), 1'b1, PORT_1);
    send_seg(1'b1, 1'b1, 10, build_seg(10, 0, 9), 1'b0, PORT_2);
    wait_drain("t4");

    // 5) Reset while sub-beat 3 of a packet is on the output
    base = hs_total;
    send_pkt(64, 1'b1, PORT_3, 11, 0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #3;
      if (hs_total >= base + 3) begin
        ok = 1;
        break;
      end
    end
    check("t5_reached_sub3", 128'(ok), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t5_tvalid", 128'(egr_tvalid), 128'(0));
    check("t5_tlast", 128'(egr_tlast), 128'(0));
    check("t5_tkeep", 128'(egr_tkeep), 128'(0));
    check("t5_occ", 128'(fifo_occ), 128'(0));
    check("t5_lu_tready", 128'(lu_tready), 128'(0));
    apply_reset();
    @(posedge clk);
    #1;
    check("t5_ready_back", 128'(lu_tready), 128'(1));
    hs_cyc.delete();
    send_pkt(65, 1'b1, PORT_0, 12, 0);
    wait_drain("t5");
    check("t5_beats", 128'(hs_cyc.size()), 128'(9));

    // 6) Mixed lengths, random gaps and random egress ready
    rdy_mode = 2;
    tl0 = tlast_cnt;
    begin
      int lens[10] = '{1, 7, 8, 63, 64, 65, 127, 200, 1500, 9000};
      for (int i = 0; i < 10; i++)
        send_pkt(lens[i], 1'(i), PORT_E'(i % 4), 20 + i, 1);
    end
    wait_drain("t6");
    check("t6_tlast_cnt", 128'(tlast_cnt - tl0), 128'(10));
    check("t6_occ_empty", 128'(fifo_occ), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
